// File: rtl/psr_skid.sv
// Two-entry skid stage with field patching, RUN/BUBBLE null-slot control and flush.
// Optional stall counter output enabled by defining PSR_STALL_CNT_EN.
module psr_skid #(
  parameter int WIDTH   = 34,
  parameter int FLD_LSB = 8,
  parameter int FLD_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ld_fld,
  input  logic             flush,
  input  logic             bubble,
  input  logic             bubble_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PSR_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] FLD_MASK =
    ((WIDTH'(1) << FLD_W) - WIDTH'(1)) << FLD_LSB;

  function automatic logic [WIDTH-1:0] patch_fld(input logic [WIDTH-1:0] old_v,
                                                 input logic [WIDTH-1:0] new_v);
    return (old_v & ~FLD_MASK) | (new_v & FLD_MASK);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q;
  logic             run_s, acc_s, xfer_s;

  // rdy_q keeps in_ready low until the first clock edge after reset release
  assign run_s     = (state_q == RUN);
  assign in_ready  = rdy_q && !skid_vld_q && run_s;
  assign out_valid = main_vld_q && run_s;
  assign out_data  = run_s ? main_q : {WIDTH{1'b0}};
  assign acc_s     = in_valid && in_ready;
  assign xfer_s    = out_valid && out_ready;

  // Next-state: flush first, then bubble entry, then normal accept/transfer
  always_comb begin
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      state_d    = RUN;
      main_d     = {WIDTH{1'b0}};
      skid_d     = {WIDTH{1'b0}};
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bubble) begin
            state_d = BUBBLE;
          end else begin
            if (xfer_s) begin
              if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
              end else begin
                main_vld_d = 1'b0;
              end
            end else begin
              main_vld_d = main_vld_q;
            end
            if (acc_s && !ld_fld) begin
              if ((!main_vld_q || xfer_s) && !skid_vld_q) begin
                main_d     = in_data;
                main_vld_d = 1'b1;
              end else begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
              end
            end else if (acc_s && ld_fld) begin
              // Youngest entry is patched; a main entry leaving this cycle is not
              if (skid_vld_q) begin
                if (xfer_s) begin
                  main_d = patch_fld(skid_q, in_data);
                end else begin
                  skid_d = patch_fld(skid_q, in_data);
                end
              end else if (main_vld_q && !xfer_s) begin
                main_d = patch_fld(main_q, in_data);
              end else begin
                main_d = main_d;
              end
            end else begin
              skid_d = skid_d;
            end
          end
        end
        BUBBLE: begin
          if (bubble_clr) begin
            state_d = RUN;
          end else begin
            state_d = BUBBLE;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Stage storage and state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= RUN;
      main_q     <= {WIDTH{1'b0}};
      skid_q     <= {WIDTH{1'b0}};
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= 1'b1;
    end
  end

`ifdef PSR_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of cycles where a valid output is held back
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_psr_skid.sv
// Testbench for psr_skid: directed vector table, hand sequences and a randomized
// run against a queue-based reference model.
module tb_psr_skid;
  localparam int W = 34;

  logic         clk = 1'b0;
  logic         clr;
  logic [W-1:0] in_data;
  logic         in_valid, in_ready, ld_fld, flush, bubble, bubble_clr;
  logic [W-1:0] out_data;
  logic         out_valid, out_ready;
`ifdef PSR_STALL_CNT_EN
  logic [1:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psr_skid #(.WIDTH(W), .FLD_LSB(8), .FLD_W(8), .CNT_W(2)) dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ld_fld(ld_fld), .flush(flush), .bubble(bubble), .bubble_clr(bubble_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PSR_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ld, fl, bb, bc, ordy;
    logic         ev;
    logic [W-1:0] ed;
    logic         cd;
    logic         eir;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic iv, input logic [W-1:0] d, input logic ld,
                              input logic fl, input logic bb, input logic bc, input logic ordy,
                              input logic ev, input logic [W-1:0] ed, input logic cd,
                              input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.ld = ld; v.fl = fl; v.bb = bb; v.bc = bc; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.cd = cd; v.eir = eir;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ld, input logic fl,
                       input logic bb, input logic bc, input logic ordy);
    in_valid = iv; in_data = d; ld_fld = ld; flush = fl;
    bubble = bb; bubble_clr = bc; out_ready = ordy;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    drive(1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  // Reference model state
  logic [W-1:0] mq[$];
  bit           mbub;
  logic [W-1:0] fmask;

  initial begin
    logic         exp_ov, exp_ir, xf, ac;
    logic         r_iv, r_ld, r_fl, r_bb, r_bc, r_or;
    logic [W-1:0] r_d;
    int           pre;
    logic [1:0]   exp_cnt[5];

    fmask = {W{1'b0}};
    for (int i = 8; i < 16; i++) fmask[i] = 1'b1;

    // Reset behaviour
    clr = 1'b0;
    drive(1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready_held", in_ready, 0);
    clr = 1'b1;
    #1;
    chk("rst_in_ready_pre_edge", in_ready, 0);
    @(negedge clk);
    chk("rst_in_ready_post_edge", in_ready, 1);

    //             iv  data          ld fl bb bc or   ev  exp data      cd eir
    tbl[0]  = mk(1, 34'h1,          0, 0, 0, 0, 1,   1, 34'h1,          1, 1);
    tbl[1]  = mk(1, 34'h2,          0, 0, 0, 0, 1,   1, 34'h2,          1, 1);
    tbl[2]  = mk(1, 34'h3,          0, 0, 0, 0, 1,   1, 34'h3,          1, 1);
    tbl[3]  = mk(0, 34'h0,          0, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[4]  = mk(1, 34'hA,          0, 0, 0, 0, 0,   1, 34'hA,          1, 1);
    tbl[5]  = mk(1, 34'hB,          0, 0, 0, 0, 0,   1, 34'hA,          1, 0);
    tbl[6]  = mk(0, 34'h0,          0, 0, 0, 0, 1,   1, 34'hB,          1, 1);
    tbl[7]  = mk(0, 34'h0,          0, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[8]  = mk(1, 34'h100,        0, 0, 0, 0, 0,   1, 34'h100,        1, 1);
    tbl[9]  = mk(1, 34'hAB00,       1, 0, 0, 0, 0,   1, 34'hAB00,       1, 1);
    tbl[10] = mk(1, 34'h5500,       1, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[11] = mk(1, 34'hFF00,       1, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[12] = mk(1, 34'h2_1234_5678, 0, 0, 0, 0, 0,  1, 34'h2_1234_5678, 1, 1);
    tbl[13] = mk(1, 34'h3_FFFF_CDFF, 1, 0, 0, 0, 0,  1, 34'h2_1234_CD78, 1, 1);
    tbl[14] = mk(0, 34'h0,          0, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[15] = mk(1, 34'h11,         0, 0, 0, 0, 0,   1, 34'h11,         1, 1);
    tbl[16] = mk(1, 34'h22,         0, 0, 0, 0, 0,   1, 34'h11,         1, 0);
    tbl[17] = mk(0, 34'h0,          0, 0, 1, 0, 0,   0, 34'h0,          1, 0);
    tbl[18] = mk(1, 34'h99,         0, 0, 1, 0, 1,   0, 34'h0,          1, 0);
    tbl[19] = mk(0, 34'h0,          0, 0, 0, 1, 0,   1, 34'h11,         1, 0);
    tbl[20] = mk(0, 34'h0,          0, 0, 0, 0, 1,   1, 34'h22,         1, 1);
    tbl[21] = mk(0, 34'h0,          0, 0, 0, 0, 1,   0, 34'h0,          0, 1);
    tbl[22] = mk(1, 34'h33,         0, 0, 0, 0, 0,   1, 34'h33,         1, 1);
    tbl[23] = mk(1, 34'h44,         0, 0, 0, 0, 0,   1, 34'h33,         1, 0);
    tbl[24] = mk(1, 34'h55,         0, 1, 0, 0, 0,   0, 34'h0,          1, 1);
    tbl[25] = mk(0, 34'h0,          0, 0, 0, 0, 1,   0, 34'h0,          1, 1);
    tbl[26] = mk(0, 34'h0,          0, 1, 1, 0, 0,   0, 34'h0,          1, 1);
    tbl[27] = mk(0, 34'h0,          0, 0, 1, 1, 0,   0, 34'h0,          1, 0);
    tbl[28] = mk(0, 34'h0,          0, 0, 1, 1, 0,   0, 34'h0,          1, 1);

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ld, tbl[i].fl, tbl[i].bb, tbl[i].bc, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].eir);
      if (tbl[i].cd || tbl[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].ed);
    end

    // Reset asserted mid-cycle with both entries held
    drive(1'b1, 34'h61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 34'h62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_pre_in_ready", in_ready, 0);
    drive(1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 clr = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("midrst_after_in_ready", in_ready, 1);
    chk("midrst_after_out_valid", out_valid, 0);

`ifdef PSR_STALL_CNT_EN
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    drive(1'b1, 34'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_cnt_start", stall_cnt, 0);
    drive(1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_cnt_%0d", i), stall_cnt, exp_cnt[i]);
    end
    drive(1'b0, {W{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_cnt_flush", stall_cnt, 0);
`endif

    // Randomized run against the reference model
    do_reset();
    mq.delete();
    mbub = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ov = !mbub && (mq.size() > 0);
      exp_ir = !mbub && (mq.size() < 2);
      chk("rnd_out_valid", out_valid, exp_ov);
      chk("rnd_in_ready", in_ready, exp_ir);
      if (exp_ov) chk("rnd_out_data", out_data, mq[0]);
      else if (mbub) chk("rnd_out_data_bubble", out_data, 0);

      r_iv = ($urandom_range(99) < 70);
      r_ld = ($urandom_range(99) < 15);
      r_fl = ($urandom_range(99) < 3);
      r_bb = ($urandom_range(99) < 5);
      r_bc = ($urandom_range(99) < 25);
      r_or = ($urandom_range(99) < 60);
      r_d  = W'({$urandom(), $urandom()});
      drive(r_iv, r_d, r_ld, r_fl, r_bb, r_bc, r_or);

      if (r_fl) begin
        mq.delete();
        mbub = 1'b0;
      end else if (mbub) begin
        if (r_bc) mbub = 1'b0;
      end else if (r_bb) begin
        mbub = 1'b1;
      end else begin
        xf  = exp_ov && r_or;
        ac  = r_iv && exp_ir;
        pre = mq.size();
        if (xf) void'(mq.pop_front());
        if (ac && !r_ld) mq.push_back(r_d);
        else if (ac && r_ld && !(pre == 0 || (pre == 1 && xf)))
          mq[mq.size()-1] = (mq[mq.size()-1] & ~fmask) | (r_d & fmask);
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/psr_skid.md
PSR_SKID -- requirements
Module: psr_skid

Interface
REQ-001 Parameter WIDTH, default 34: stage payload width in bits.
REQ-002 Parameter FLD_LSB, default 8: LSB of the patchable field.
REQ-003 Parameter FLD_W, default 8: patchable field width; FLD_LSB+FLD_W <= WIDTH.
REQ-004 Parameter CNT_W, default 16: stall counter width, used only with PSR_STALL_CNT_EN.
REQ-005 clk  in  1  sole clock, all state updates on its rising edge.
REQ-006 clr  in  1  reset, asynchronous and active-low.
REQ-007 in_data  in  WIDTH  upstream payload.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_ready  out  1  stage can accept this cycle.
REQ-010 ld_fld  in  1  qualifies the offered beat as a field patch, not a new entry.
REQ-011 flush  in  1  synchronous discard of all entries.
REQ-012 bubble  in  1  request to insert a null slot.
REQ-013 bubble_clr  in  1  release of an active bubble.
REQ-014 out_data  out  WIDTH  registered downstream payload.
REQ-015 out_valid  out  1  out_data is valid.
REQ-016 out_ready  in  1  downstream accepts this cycle.

Function
REQ-017 Storage: main entry (drives out_data/out_valid) plus one skid entry, each with a valid bit.
REQ-018 Accept = in_valid && in_ready; transfer = out_valid && out_ready.
REQ-019 in_ready = !skid_valid && state==RUN, registered-path only (no combinational path from out_ready).
REQ-020 Accept with ld_fld=0: load main if main empty or transferring and skid empty; else load skid.
REQ-021 Transfer with skid valid: skid moves to main, skid empties, same cycle as any accept (accept then loads skid).
REQ-022 Latency: accepted beat visible on out_data one cycle after accept when main free; zero bubbles at full throughput.
REQ-023 Accept with ld_fld=1: replace bits [FLD_LSB+FLD_W-1:FLD_LSB] of youngest valid entry (skid if valid, else main), other bits unchanged, no new entry allocated.
REQ-024 Patch with no valid entry, or targeting main while main transfers that cycle: dropped, no other effect.
REQ-025 State machine RUN/BUBBLE; RUN -> BUBBLE when bubble=1; BUBBLE -> RUN when bubble_clr=1.
REQ-026 In BUBBLE: out_valid=0, out_data=0, in_ready=0, stored entries held unchanged; bubble ignored while in BUBBLE.
REQ-027 bubble and bubble_clr both 1 in RUN: enter BUBBLE; in BUBBLE: return to RUN.
REQ-028 Priority: clr > flush > bubble entry > normal accept/transfer.
REQ-029 flush: next cycle both valids 0, out_data 0, state RUN; concurrent accept discarded.

Reset
REQ-030 clr=0 immediately forces out_valid=0, out_data=0, skid cleared, state RUN, in_ready=0 while held, stall_cnt=0.
REQ-031 After clr deasserts, in_ready=1 from first rising clk edge; reset mid-transfer loses all entries.

Configuration
REQ-032 Macro PSR_STALL_CNT_EN defined: output stall_cnt [CNT_W] counts cycles with out_valid && !out_ready, saturating at all-ones, zeroed by flush.
REQ-033 Macro undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-034 clr low then high; in_valid=1 data 0x1,0x2,0x3 each cycle, out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, in_ready stays 1.
REQ-035 main=0xA valid, out_ready=0, accept 0xB -> skid full, in_ready=0; out_ready=1 -> out 0xA then 0xB, in_ready back to 1.
REQ-036 main=0x000000100 held, ld_fld=1 in_data=0x00000AB00 -> main becomes 0x00000AB00; same patch with main transferring and skid empty -> dropped.
REQ-037 bubble=1 with two entries held -> out_valid=0, out_data=0, in_ready=0; bubble_clr=1 -> original entries emerge in order.
REQ-038 flush with both entries valid and in_valid=1 -> next cycle out_valid=0, skid empty, in_ready=1, input beat lost.
REQ-039 PSR_STALL_CNT_EN, CNT_W=2: out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; flush -> 0.
